// File: rtl/data_mem_if.sv
// Core data-memory bus: request/ready from the core, response strobe back.
interface data_mem_if;
  logic        data_mem_req_i;
  logic [63:0] data_mem_addr_i;
  logic [1:0]  data_mem_byte_en_i;
  logic        data_mem_wr_i;
  logic [63:0] data_mem_wr_data_i;
  logic        data_mem_ready_o;
  logic        data_mem_rsp_valid_o;
  logic [63:0] data_mem_rd_data_o;
  logic        data_mem_err_o;

  // Core side: issues requests, consumes responses.
  modport master (
    output data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
           data_mem_wr_i, data_mem_wr_data_i,
    input  data_mem_ready_o, data_mem_rsp_valid_o, data_mem_rd_data_o,
           data_mem_err_o
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i,
           data_mem_wr_i, data_mem_wr_data_i,
    output data_mem_ready_o, data_mem_rsp_valid_o, data_mem_rd_data_o,
           data_mem_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: services core load/store requests against a
// 64-bit-wide SRAM with fixed latency, flagging misaligned/out-of-range accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  WAIT     = 2'd1;
  localparam logic [1:0]  RESP     = 2'd2;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [63:0]   addr_q;
  logic [63:0]   wr_data_q;
  logic [1:0]    size_q;
  logic          wr_q;

  logic          ready;
  logic          accept;
  logic          enter_resp;

  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_wr;

  logic [63:0]   offset;
  logic [2:0]    lane;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [7:0]    size_bytes;
  logic [63:0]   size_mask;
  logic [7:0]    lane_en;
  logic [63:0]   wdata_sh;
  logic [63:0]   rdata_sh;

  logic          rsp_valid;
  logic [63:0]   rd_data;
  logic          err;

  logic [63:0]   mem [DEPTH];

  // Ready whenever not busy counting down; held low while reset is asserted.
  always_comb begin
    ready      = !reset && ((state == IDLE) || (state == RESP));
    accept     = bus.data_mem_req_i && ready;
    enter_resp = ((state == WAIT) && (cnt == '0)) || ((LATENCY == 1) && accept);
  end

  // With LATENCY==1 the access happens on the accepting edge itself, so the
  // live bus fields are used instead of the latched copies.
  always_comb begin
    if (LATENCY == 1) begin
      acc_addr  = bus.data_mem_addr_i;
      acc_wdata = bus.data_mem_wr_data_i;
      acc_size  = bus.data_mem_byte_en_i;
      acc_wr    = bus.data_mem_wr_i;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wr_data_q;
      acc_size  = size_q;
      acc_wr    = wr_q;
    end
  end

  // Address decode, error detection and lane alignment of store/load data.
  always_comb begin
    offset   = acc_addr - BASE_ADDR;
    lane     = offset[2:0];
    word_idx = offset[AW+2:3];
    case (acc_size)
      2'd0: begin size_bytes = 8'h01; size_mask = 64'h0000_0000_0000_00FF; misaligned = 1'b0;      end
      2'd1: begin size_bytes = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; misaligned = lane[0];   end
      2'd2: begin size_bytes = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; misaligned = |lane[1:0]; end
      default: begin size_bytes = 8'hFF; size_mask = '1;                   misaligned = |lane;      end
    endcase
    out_of_range = (acc_addr < BASE_ADDR) || (offset[63:AW+3] != '0);
    acc_err      = misaligned || out_of_range;
    lane_en      = size_bytes << lane;
    wdata_sh     = acc_wdata << {lane, 3'b000};
    rdata_sh     = (mem[word_idx] >> {lane, 3'b000}) & size_mask;
  end

  // SRAM array: byte-lane store commit on the edge entering RESP; never reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_wr && !acc_err) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (lane_en[b]) begin
          mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  // Control FSM, latency counter and request latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= bus.data_mem_addr_i;
        wr_data_q <= bus.data_mem_wr_data_i;
        size_q    <= bus.data_mem_byte_en_i;
        wr_q      <= bus.data_mem_wr_i;
      end
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            state <= (LATENCY == 1) ? RESP : WAIT;
            cnt   <= CNT_INIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response strobe and held read data / error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        err     <= acc_err;
        rd_data <= (acc_err || acc_wr) ? '0 : rdata_sh;
      end
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.data_mem_ready_o     = ready;
    bus.data_mem_rsp_valid_o = rsp_valid;
    bus.data_mem_rd_data_o   = rd_data;
    bus.data_mem_err_o       = err;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes expected responses,
// negedge monitor pops and compares whenever rsp_valid is seen.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   nrsp = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];

  data_mem_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_mem_rsp_valid_o === 1'b1) begin
      nrsp++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        check("rsp_err", {63'd0, bus.data_mem_err_o}, {63'd0, e.err});
        check("rsp_data", bus.data_mem_rd_data_o, e.data);
      end
    end
  end

  // Issue one request starting at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic exp_err,
                       input logic [63:0] exp_data, output int acc_cyc);
    exp_t e;
    bus.data_mem_req_i     = 1'b1;
    bus.data_mem_wr_i      = wr;
    bus.data_mem_byte_en_i = size;
    bus.data_mem_addr_i    = addr;
    bus.data_mem_wr_data_i = wdata;
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.data_mem_ready_o === 1'b1) begin
        acc_cyc = cyc;
        e.cyc  = cyc + LAT;
        e.err  = exp_err;
        e.data = exp_data;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept for addr %h expected accept", addr);
    end
  endtask

  task automatic drop_req();
    bus.data_mem_req_i = 1'b0;
  endtask

  // Wait (bounded) until all expected responses have been seen.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // One request with req dropped and responses drained afterwards.
  task automatic xfer(input logic wr, input logic [1:0] size, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic exp_err, input logic [63:0] exp_data);
    int a;
    issue(wr, size, addr, wdata, exp_err, exp_data, a);
    drop_req();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a1;
    int a2;
    int nrsp_before;

    reset                  = 1'b1;
    bus.data_mem_req_i     = 1'b0;
    bus.data_mem_wr_i      = 1'b0;
    bus.data_mem_byte_en_i = 2'd0;
    bus.data_mem_addr_i    = '0;
    bus.data_mem_wr_data_i = '0;

    // 1: reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", {63'd0, bus.data_mem_ready_o}, 64'd1);
    check("reset_rsp_valid", {63'd0, bus.data_mem_rsp_valid_o}, 64'd0);
    check("reset_rd_data", bus.data_mem_rd_data_o, 64'd0);
    check("reset_err", {63'd0, bus.data_mem_err_o}, 64'd0);
    @(negedge clk);

    // Known contents at word 0 and the last word for later no-write checks
    xfer(1'b1, 2'd3, 64'h0,    64'hCAFEF00D_12345678, 1'b0, 64'd0);
    xfer(1'b1, 2'd3, 64'h1FF8, 64'h0F0E0D0C_0B0A0908, 1'b0, 64'd0);

    // 2: dword store/load round trip
    xfer(1'b1, 2'd3, 64'h10, 64'h11223344_55667788, 1'b0, 64'd0);
    xfer(1'b0, 2'd3, 64'h10, 64'd0, 1'b0, 64'h11223344_55667788);

    // 3: byte store merges into one lane; sub-word loads right-justified
    xfer(1'b1, 2'd0, 64'h13, 64'hFFFFFFFF_FFFFFFAB, 1'b0, 64'd0);
    xfer(1'b0, 2'd3, 64'h10, 64'd0, 1'b0, 64'h11223344_AB667788);
    xfer(1'b0, 2'd1, 64'h12, 64'd0, 1'b0, 64'h00000000_0000AB66);
    xfer(1'b0, 2'd0, 64'h17, 64'd0, 1'b0, 64'h00000000_00000011);
    xfer(1'b0, 2'd2, 64'h14, 64'd0, 1'b0, 64'h00000000_11223344);

    // 4: misaligned and out-of-range errors, no array write
    xfer(1'b0, 2'd2, 64'h12, 64'd0, 1'b1, 64'd0);
    xfer(1'b0, 2'd1, 64'h11, 64'd0, 1'b1, 64'd0);
    xfer(1'b1, 2'd3, BASE + 64'(DEPTH) * 8, 64'hDEADBEEF_DEADBEEF, 1'b1, 64'd0);
    xfer(1'b1, 2'd3, 64'h1FFC, 64'hDEADBEEF_DEADBEEF, 1'b1, 64'd0);
    xfer(1'b0, 2'd3, 64'h0,    64'd0, 1'b0, 64'hCAFEF00D_12345678);
    xfer(1'b0, 2'd3, 64'h1FF8, 64'd0, 1'b0, 64'h0F0E0D0C_0B0A0908);

    // 5: req held high across two transactions
    issue(1'b1, 2'd3, 64'h18, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 64'd0, a1);
    #1;
    check("wait_ready_low", {63'd0, bus.data_mem_ready_o}, 64'd0);
    issue(1'b0, 2'd3, 64'h18, 64'd0, 1'b0, 64'hA5A5A5A5_5A5A5A5A, a2);
    drop_req();
    check("b2b_accept_gap", 64'(a2 - a1), 64'(LAT));
    drain();

    // 6: reset during WAIT discards the store
    xfer(1'b1, 2'd3, 64'h20, 64'h01234567_89ABCDEF, 1'b0, 64'd0);
    issue(1'b1, 2'd3, 64'h20, 64'hFFFF0000_FFFF0000, 1'b0, 64'd0, a1);
    drop_req();
    nrsp_before = nrsp;
    reset = 1'b1;
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_rsp", 64'(nrsp - nrsp_before), 64'd0);
    check("abort_ready", {63'd0, bus.data_mem_ready_o}, 64'd1);
    xfer(1'b0, 2'd3, 64'h20, 64'd0, 1'b0, 64'h01234567_89ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
